// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-add-3 binary-to-BCD converter, one bit per clock. Ports: clk, clr (async reset), start/bin in; busy, done pulse, held packed bcd out
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sr_q, sr_d;
    logic [4*DIGITS-1:0]   sc_q, sc_d, sc_adj;
    logic [CW-1:0]         count_q, count_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  done_q, done_d;
    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            sc_adj[4*i+:4] = sc_q[4*i+:4] >= 4'd5 ? sc_q[4*i+:4] + 4'd3 : sc_q[4*i+:4];
    end
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        sc_d    = sc_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                sr_d    = bin;
                sc_d    = '0;
                count_d = CW'(WIDTH);
                state_d = SHIFT;
            end
            SHIFT: begin
                {sc_d, sr_d} = {sc_adj, sr_q} << 1;
                count_d      = count_q - CW'(1);
                state_d      = count_q == CW'(1) ? DONE : SHIFT;
            end
            DONE: begin
                bcd_d   = sc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            sc_q    <= '0;
            count_q <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            sc_q    <= sc_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and sweep checks of bin2bcd_seq results, latency, hold and reset behaviour
module tb_bin2bcd_seq;
    logic        clk = 1'b0, clr = 1'b0, start = 1'b0;
    logic [7:0]  bin = '0;
    logic        busy, done;
    logic [11:0] bcd;
    logic [11:0] prev_bcd = '0;
    int          total = 0, bad = 0, stab = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .clr(clr), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 30) begin
            if (bcd !== prev_bcd) stab++;
            @(negedge clk);
            n++;
        end
        chk("done seen", {31'd0, done}, 32'd1);
        prev_bcd = bcd;
    endtask

    task automatic convert(input logic [7:0] v, input string tag);
        int n;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        chk({tag, " lat"}, n, 9);
        chk(tag, {20'd0, bcd}, {20'd0, ref_bcd(int'(v))});
    endtask

    initial begin
        int n, dc;
        #2 clr = 1'b1;
        #1;
        chk("rst bcd", {20'd0, bcd}, 32'h0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        convert(8'd255, "c255");
        convert(8'd0, "c0");
        @(negedge clk);
        chk("c0 pulse len", {31'd0, done}, 32'd0);
        convert(8'd99, "c99");
        convert(8'd100, "c100");
        chk("c100 value", {20'd0, bcd}, 32'h100);
        stab = 0;
        for (int v = 0; v < 256; v++) convert(8'(v), "sweep");
        chk("sweep stable", stab, 0);
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(negedge clk);
        bin = 8'd7;
        wait_done(n);
        chk("c200 held", {20'd0, bcd}, 32'h200);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("c7 lat", n, 9);
        chk("c7", {20'd0, bcd}, 32'h007);
        @(negedge clk);
        bin   = 8'd77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr bcd", {20'd0, bcd}, 32'h0);
        chk("clr busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        prev_bcd = '0;
        dc       = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("clr no done", dc, 0);
        convert(8'd128, "c128");
        chk("c128 value", {20'd0, bcd}, 32'h128);
        convert(8'd42, "c42");
        bin   = 8'd137;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("b2b gap", n + 1, 10);
        chk("c137", {20'd0, bcd}, 32'h137);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
